// File: rtl/safebox_pkg.sv
// Shared types and widths for the 4-bit safe box.
// Imported by the attempt guard, keypad and alarm stages.
package safebox_pkg;

    localparam int FAIL_W       = 4;
    localparam int SEC_W        = 8;
    localparam int TICK_DIV_DEF = 50000000;

    typedef enum logic [2:0] {
        ARMED = 3'b001,
        OPEN  = 3'b010,
        ALARM = 3'b100
    } guard_state_e;

endpackage

// File: rtl/sec_tick.sv
// One-second prescaler with synchronous restart.
// tick is high for the single cycle the count sits at TICK_DIV-1.
module sec_tick #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign tick   = w_last;

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/attempt_guard.sv
// Tracks consecutive wrong codes, drives the unlock window
// and holds a timed alarm/lockout after MAX_FAIL failures.
module attempt_guard
    import safebox_pkg::*;
#(
    parameter int MAX_FAIL  = 3,
    parameter int TICK_DIV  = TICK_DIV_DEF,
    parameter int OPEN_SEC  = 5,
    parameter int ALARM_SEC = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              check_valid,
    input  logic              check_ok,
    input  logic              alarm_clr,
    output logic              unlocked,
    output logic              alarm,
    output logic              locked_out,
    output logic [FAIL_W-1:0] fail_cnt,
    output logic [SEC_W-1:0]  remain_sec
);

    localparam logic [FAIL_W-1:0] MAX_F   = FAIL_W'(MAX_FAIL);
    localparam logic [FAIL_W:0]   MAX_F_X = (FAIL_W + 1)'(MAX_FAIL);
    localparam logic [SEC_W-1:0]  OPEN_S  = SEC_W'(OPEN_SEC);
    localparam logic [SEC_W-1:0]  ALARM_S = SEC_W'(ALARM_SEC);

    guard_state_e      r_state;
    guard_state_e      w_nxt_state;
    logic [FAIL_W-1:0] r_fail;
    logic [FAIL_W-1:0] w_nxt_fail;
    logic [SEC_W-1:0]  r_remain;
    logic [SEC_W-1:0]  w_nxt_remain;
    logic              r_unlocked;
    logic              r_alarm;
    logic              r_locked;
    logic              w_restart;
    logic              w_tick;
    logic [FAIL_W:0]   w_fail_inc;

    sec_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_sec_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (w_restart),
        .tick    (w_tick)
    );

    assign w_fail_inc = {1'b0, r_fail} + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ARMED;
            r_fail     <= '0;
            r_remain   <= '0;
            r_unlocked <= 1'b0;
            r_alarm    <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_fail     <= w_nxt_fail;
            r_remain   <= w_nxt_remain;
            r_unlocked <= (w_nxt_state == OPEN);
            r_alarm    <= (w_nxt_state == ALARM);
            r_locked   <= (w_nxt_state == ALARM);
        end
    end

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_fail   = r_fail;
        w_nxt_remain = r_remain;
        w_restart    = 1'b0;
        unique case (r_state)
            ARMED: begin
                if (alarm_clr) begin
                    w_nxt_fail = '0;
                end else if (check_valid) begin
                    w_restart = 1'b1;
                    if (check_ok) begin
                        w_nxt_state  = OPEN;
                        w_nxt_fail   = '0;
                        w_nxt_remain = OPEN_S;
                    end else if (w_fail_inc < MAX_F_X) begin
                        w_nxt_fail = w_fail_inc[FAIL_W-1:0];
                        w_restart  = 1'b0;
                    end else begin
                        w_nxt_state  = ALARM;
                        w_nxt_fail   = MAX_F;
                        w_nxt_remain = ALARM_S;
                    end
                end
            end
            OPEN: begin
                if (w_tick) begin
                    if (r_remain <= 8'd1) begin
                        w_nxt_state  = ARMED;
                        w_nxt_remain = '0;
                        w_restart    = 1'b1;
                    end else begin
                        w_nxt_remain = r_remain - 1'b1;
                    end
                end
            end
            ALARM: begin
                if (alarm_clr) begin
                    w_nxt_state  = ARMED;
                    w_nxt_fail   = '0;
                    w_nxt_remain = '0;
                    w_restart    = 1'b1;
                end else if (w_tick) begin
                    if (r_remain <= 8'd1) begin
                        w_nxt_state  = ARMED;
                        w_nxt_fail   = '0;
                        w_nxt_remain = '0;
                        w_restart    = 1'b1;
                    end else begin
                        w_nxt_remain = r_remain - 1'b1;
                    end
                end
            end
            default: begin
                // Corrupted one-hot state: fall back to a clean ARMED
                w_nxt_state  = ARMED;
                w_nxt_fail   = '0;
                w_nxt_remain = '0;
                w_restart    = 1'b1;
            end
        endcase
    end

    assign unlocked   = r_unlocked;
    assign alarm      = r_alarm;
    assign locked_out = r_locked;
    assign fail_cnt   = r_fail;
    assign remain_sec = r_remain;

endmodule

// File: tb/tb_attempt_guard.sv
// Directed bench for attempt_guard with a 4-cycle second,
// 2 s open window, 3 s alarm and three allowed failures.
module tb_attempt_guard;

    logic       clk;
    logic       rst_n;
    logic       check_valid;
    logic       check_ok;
    logic       alarm_clr;
    logic       unlocked;
    logic       alarm;
    logic       locked_out;
    logic [3:0] fail_cnt;
    logic [7:0] remain_sec;

    int n_pass;
    int n_total;

    attempt_guard #(
        .MAX_FAIL  (3),
        .TICK_DIV  (4),
        .OPEN_SEC  (2),
        .ALARM_SEC (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .check_valid (check_valid),
        .check_ok    (check_ok),
        .alarm_clr   (alarm_clr),
        .unlocked    (unlocked),
        .alarm       (alarm),
        .locked_out  (locked_out),
        .fail_cnt    (fail_cnt),
        .remain_sec  (remain_sec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input int u, input int a,
                           input int f, input int r);
        chk({tag, ".unlocked"}, int'(unlocked), u);
        chk({tag, ".alarm"}, int'(alarm), a);
        chk({tag, ".locked_out"}, int'(locked_out), a);
        chk({tag, ".fail_cnt"}, int'(fail_cnt), f);
        chk({tag, ".remain_sec"}, int'(remain_sec), r);
    endtask

    task automatic strobe(input logic ok);
        check_valid = 1'b1;
        check_ok    = ok;
        step(1);
        check_valid = 1'b0;
        check_ok    = 1'b0;
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        rst_n       = 1'b0;
        check_valid = 1'b0;
        check_ok    = 1'b0;
        alarm_clr   = 1'b0;

        // reset with check_valid toggling
        step(1);
        chk_all("rst0", 0, 0, 0, 0);
        check_valid = 1'b1;
        step(1);
        chk_all("rst1", 0, 0, 0, 0);
        check_valid = 1'b0;
        rst_n = 1'b1;
        step(1);
        chk_all("rst_rel", 0, 0, 0, 0);

        // correct code: open window of 2 s
        strobe(1'b1);
        chk_all("ok_t1", 1, 0, 0, 2);
        step(4);
        chk_all("ok_t5", 1, 0, 0, 1);
        step(3);
        chk_all("ok_t8", 1, 0, 0, 1);
        step(1);
        chk_all("ok_t9", 0, 0, 0, 0);

        // three wrong codes -> alarm, auto rearm after 12 cycles
        strobe(1'b0);
        chk_all("w1", 0, 0, 1, 0);
        step(1);
        strobe(1'b0);
        chk_all("w2", 0, 0, 2, 0);
        step(1);
        strobe(1'b0);
        chk_all("w3_alarm", 0, 1, 3, 3);
        step(4);
        chk_all("alarm_a4", 0, 1, 3, 2);
        step(7);
        chk_all("alarm_a11", 0, 1, 3, 1);
        step(1);
        chk_all("alarm_a12", 0, 0, 0, 0);

        // mixed attempts
        strobe(1'b0);
        chk_all("mix_w1", 0, 0, 1, 0);
        strobe(1'b0);
        chk_all("mix_w2", 0, 0, 2, 0);
        strobe(1'b1);
        chk_all("mix_ok", 1, 0, 0, 2);
        strobe(1'b0);
        chk_all("open_ign", 1, 0, 0, 2);
        step(7);
        chk_all("mix_close", 0, 0, 0, 0);
        strobe(1'b0);
        chk_all("mix_after", 0, 0, 1, 0);

        // alarm interference, then admin clear
        strobe(1'b0);
        strobe(1'b0);
        chk_all("intf_entry", 0, 1, 3, 3);
        strobe(1'b1);
        chk_all("intf_a1", 0, 1, 3, 3);
        step(1);
        strobe(1'b1);
        chk_all("intf_a3", 0, 1, 3, 3);
        step(2);
        chk_all("intf_a5", 0, 1, 3, 2);
        alarm_clr = 1'b1;
        step(1);
        alarm_clr = 1'b0;
        chk_all("intf_clr", 0, 0, 0, 0);
        step(6);
        chk_all("intf_stay", 0, 0, 0, 0);

        // clear and wrong code in the same cycle at fail_cnt=2
        strobe(1'b0);
        strobe(1'b0);
        chk_all("sim_pre", 0, 0, 2, 0);
        alarm_clr = 1'b1;
        strobe(1'b0);
        alarm_clr = 1'b0;
        chk_all("sim_clr", 0, 0, 0, 0);

        // reset in the middle of an alarm
        strobe(1'b0);
        strobe(1'b0);
        strobe(1'b0);
        chk_all("rst_alarm_in", 0, 1, 3, 3);
        step(2);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        chk_all("rst_alarm", 0, 0, 0, 0);
        step(13);
        chk_all("rst_no_resid", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
